// File: rtl/slave_port_v3_if.sv
// slave_port_v3_if: bit-serial bus between a master port and slave_port_v3.
// Carries the write/read serial lines, their handshakes, and the slave's
// split/error status. Clock and reset are not carried here.
interface slave_port_v3_if;
  logic mode;
  logic wr_bus;
  logic master_valid;
  logic master_ready;
  logic rd_bus;
  logic slave_ready;
  logic slave_valid;
  logic split;
  logic error;

  modport master (
    output mode, wr_bus, master_valid, master_ready,
    input  rd_bus, slave_ready, slave_valid, split, error
  );

  modport slave (
    input  mode, wr_bus, master_valid, master_ready,
    output rd_bus, slave_ready, slave_valid, split, error
  );
endinterface

// File: rtl/slave_port_v3.sv
// slave_port_v3: bit-serial bus slave with an internal word memory.
// Header = ADDR_WIDTH address bits then LEN_WIDTH length bits (MSB first).
// Bursts of LEN+1 beats, addresses wrap modulo MEM_DEPTH; a start address
// at or beyond MEM_DEPTH produces a one-cycle error pulse.
// Optional compile-time feature: SLAVE_SPLIT_EN drives split high during
// the read latency; without it split is tied to 0.
module slave_port_v3 #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_DEPTH    = 256,
  parameter int LEN_WIDTH    = 2,
  parameter int READ_LATENCY = 4
) (
  input logic            clk,
  input logic            rst,
  slave_port_v3_if.slave bus
);

  localparam int HDR_BITS = ADDR_WIDTH + LEN_WIDTH;
  localparam int MAX_BITS = (HDR_BITS > DATA_WIDTH) ? HDR_BITS : DATA_WIDTH;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int LAT_W    = $clog2(READ_LATENCY + 1);
  localparam int IDX_W    = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LEN   = 3'd2,
    ST_DEC   = 3'd3,
    ST_ERR   = 3'd4,
    ST_WDATA = 3'd5,
    ST_RLAT  = 3'd6,
    ST_SEND  = 3'd7
  } state_t;

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic                    mode_r;
  logic [DATA_WIDTH-2:0]   wdata_r;
  logic [DATA_WIDTH-1:0]   tx_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [LEN_WIDTH-1:0]    beat_r;
  logic [LAT_W-1:0]        lat_cnt_r;
  logic                    slave_ready_r;
  logic                    slave_valid_r;
  logic                    error_r;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

  logic                    acc_s;
  logic                    cons_s;
  logic                    addr_last_s;
  logic                    hdr_last_s;
  logic                    data_last_s;
  logic                    beat_last_s;
  logic                    lat_done_s;
  logic                    oor_s;
  logic                    we_s;
  logic [DATA_WIDTH-1:0]   wr_word_s;
  logic [LEN_WIDTH-1:0]    beat_sel_s;
  logic [IDX_W-1:0]        mem_idx_s;

  assign acc_s       = bus.master_valid & slave_ready_r;
  assign cons_s      = slave_valid_r & bus.master_ready;
  assign addr_last_s = (bit_cnt_r == CNT_W'(ADDR_WIDTH - 1));
  assign hdr_last_s  = (bit_cnt_r == CNT_W'(HDR_BITS - 1));
  assign data_last_s = (bit_cnt_r == CNT_W'(DATA_WIDTH - 1));
  assign beat_last_s = (beat_r == len_r);
  assign lat_done_s  = (lat_cnt_r == LAT_W'(READ_LATENCY - 1));
  assign oor_s       = (32'(addr_r) >= 32'(MEM_DEPTH));
  assign wr_word_s   = {wdata_r, bus.wr_bus};
  assign we_s        = (state_r == ST_WDATA) & acc_s & data_last_s;

  // Memory index: in SEND it points at the next beat so the following word is ready on the last-bit edge
  always_comb begin
    beat_sel_s = beat_r;
    if (state_r == ST_SEND) begin
      beat_sel_s = beat_r + LEN_WIDTH'(1);
    end else begin
      beat_sel_s = beat_r;
    end
    mem_idx_s = addr_r[IDX_W-1:0] + IDX_W'(beat_sel_s);
  end

  // State register with synchronous reset to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.master_valid) state_nx_s = ST_ADDR;
        else                  state_nx_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (!bus.master_valid) state_nx_s = ST_IDLE;
        else if (addr_last_s)  state_nx_s = ST_LEN;
        else                   state_nx_s = ST_ADDR;
      end
      ST_LEN: begin
        if (!bus.master_valid) state_nx_s = ST_IDLE;
        else if (hdr_last_s)   state_nx_s = ST_DEC;
        else                   state_nx_s = ST_LEN;
      end
      ST_DEC: begin
        if (oor_s)       state_nx_s = ST_ERR;
        else if (mode_r) state_nx_s = ST_WDATA;
        else             state_nx_s = ST_RLAT;
      end
      ST_ERR: begin
        state_nx_s = ST_IDLE;
      end
      ST_WDATA: begin
        if (!bus.master_valid)                state_nx_s = ST_IDLE;
        else if (data_last_s && beat_last_s)  state_nx_s = ST_IDLE;
        else                                  state_nx_s = ST_WDATA;
      end
      ST_RLAT: begin
        if (lat_done_s) state_nx_s = ST_SEND;
        else            state_nx_s = ST_RLAT;
      end
      ST_SEND: begin
        if (cons_s && data_last_s && beat_last_s) state_nx_s = ST_IDLE;
        else                                       state_nx_s = ST_SEND;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: header shift-in, write assembly, latency count and send shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r    <= '0;
      len_r     <= '0;
      mode_r    <= 1'b0;
      wdata_r   <= '0;
      tx_r      <= '0;
      bit_cnt_r <= '0;
      beat_r    <= '0;
      lat_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= '0;
          beat_r    <= '0;
          lat_cnt_r <= '0;
          tx_r      <= '0;
        end
        ST_ADDR: begin
          if (acc_s) begin
            addr_r    <= (addr_r << 1) | ADDR_WIDTH'(bus.wr_bus);
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
        end
        ST_LEN: begin
          if (acc_s) begin
            len_r <= (len_r << 1) | LEN_WIDTH'(bus.wr_bus);
            if (hdr_last_s) begin
              mode_r    <= bus.mode;
              bit_cnt_r <= '0;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_DEC: begin
          bit_cnt_r <= '0;
          beat_r    <= '0;
          lat_cnt_r <= '0;
        end
        ST_ERR: begin
          bit_cnt_r <= '0;
        end
        ST_WDATA: begin
          if (acc_s) begin
            wdata_r <= (wdata_r << 1) | (DATA_WIDTH - 1)'(bus.wr_bus);
            if (data_last_s) begin
              bit_cnt_r <= '0;
              beat_r    <= beat_r + LEN_WIDTH'(1);
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_RLAT: begin
          if (lat_done_s) begin
            lat_cnt_r <= '0;
            tx_r      <= mem_r[mem_idx_s];
          end else begin
            lat_cnt_r <= lat_cnt_r + LAT_W'(1);
          end
        end
        ST_SEND: begin
          if (cons_s) begin
            if (data_last_s) begin
              bit_cnt_r <= '0;
              if (beat_last_s) begin
                tx_r <= '0;
              end else begin
                beat_r <= beat_r + LEN_WIDTH'(1);
                tx_r   <= mem_r[mem_idx_s];
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              tx_r      <= tx_r << 1;
            end
          end
        end
        default: begin
          bit_cnt_r <= '0;
        end
      endcase
    end
  end

  // Word memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[mem_idx_s] <= wr_word_s;
    end
  end

  // Registered handshake and status outputs, derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      slave_ready_r <= 1'b0;
      slave_valid_r <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      slave_ready_r <= (state_nx_s == ST_ADDR) || (state_nx_s == ST_LEN) ||
                       (state_nx_s == ST_WDATA);
      slave_valid_r <= (state_nx_s == ST_SEND);
      error_r       <= (state_nx_s == ST_ERR);
    end
  end

`ifdef SLAVE_SPLIT_EN
  logic split_r;

  // Split flag: high on every read-latency cycle, low once SEND begins
  always_ff @(posedge clk) begin
    if (rst) begin
      split_r <= 1'b0;
    end else begin
      split_r <= (state_nx_s == ST_RLAT);
    end
  end

  assign bus.split = split_r;
`else
  assign bus.split = 1'b0;
`endif

  // tx_r is zero outside SEND, so its MSB is the registered serial output
  assign bus.rd_bus      = tx_r[DATA_WIDTH-1];
  assign bus.slave_ready = slave_ready_r;
  assign bus.slave_valid = slave_valid_r;
  assign bus.error       = error_r;

endmodule

// File: doc/slave_port_v3.md
Name: slave_port_v3

Overview:
- Next-generation bit-serial bus slave with an internal word memory.
- Adds a parametrised memory depth, multi-beat bursts with address auto-increment and wrap, out-of-range error signalling, a stall-safe send path, and compile-time split support.
- Sits behind the bus interconnect, alongside existing serial slaves, and is driven by a master port.

Parameters:
ADDR_WIDTH, 12, serial address field width in bits
DATA_WIDTH, 8, word width in bits
MEM_DEPTH, 256, words of internal memory; power of two, at most 2**ADDR_WIDTH
LEN_WIDTH, 2, burst-length field width; beats = LEN+1 (1..2**LEN_WIDTH)
READ_LATENCY, 4, cycles from end of read header to first send bit; at least 1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mode  in  1  1=write, 0=read; sampled on the cycle the last header bit is accepted
wr_bus  in  1  serial data from master, MSB first
master_valid  in  1  wr_bus bit valid
master_ready  in  1  master accepts rd_bus bit
rd_bus  out  1  serial data to master, MSB first
slave_ready  out  1  slave accepts wr_bus bit
slave_valid  out  1  rd_bus bit valid
split  out  1  slave has released bus during read latency (SLAVE_SPLIT_EN only)
error  out  1  one-cycle pulse: start address out of range

Behaviour:
- Handshake: an input bit is accepted when master_valid & slave_ready; an output bit is consumed when slave_valid & master_ready.
- Reset: rst=1 forces IDLE on the next edge, from any state. rd_bus, slave_ready, slave_valid, split and error are all 0; counters clear. Memory contents are not reset.
- Header format: ADDR_WIDTH address bits, then LEN_WIDTH length bits, both MSB first.
- IDLE: slave_ready=0. Goes to ADDR when master_valid=1; that bit is not consumed.
- ADDR/LEN: slave_ready=1.
  - Each accepted bit shifts into the address or length register.
  - If master_valid=0 in ADDR/LEN/WDATA, the transfer aborts to IDLE. Beats already fully written stay written; partial beats are discarded.
- Header decode, on the cycle after the last LEN bit is accepted:
  - If addr >= MEM_DEPTH: go to ERR.
  - Else if mode=1: go to WDATA.
  - Else: go to RLAT.
- ERR: lasts one cycle with error=1, then IDLE. No memory access and no slave_valid.
- WDATA: slave_ready=1.
  - DATA_WIDTH bits per beat.
  - On the cycle the last bit of a beat is accepted, the word is written to mem[(addr+beat) mod MEM_DEPTH].
  - After beat LEN completes, go to IDLE.
- RLAT: waits READ_LATENCY cycles, then SEND. If the last header bit is accepted at edge T, slave_valid first goes high after edge T+1+READ_LATENCY.
- SEND: slave_valid=1; rd_bus carries the current bit of the word loaded from mem[(addr+beat) mod MEM_DEPTH].
  - Bit pointer advances only on slave_valid & master_ready.
  - While master_ready=0, rd_bus is held stable.
  - The next beat's word loads on the same edge the last bit of the current beat is consumed, so there is no gap between beats.
  - After the last bit of beat LEN is consumed: slave_valid=0 and go to IDLE.
- Wrap-around: the burst address wraps modulo MEM_DEPTH. The start address check is on the full ADDR_WIDTH value; a wrapped burst is not an error.
- rd_bus is 0 outside SEND.
- Counters: the bit counter is sized for max(ADDR_WIDTH+LEN_WIDTH, DATA_WIDTH); the beat counter is LEN_WIDTH bits.

Optional Feature:
- Macro: SLAVE_SPLIT_EN.
- Defined: split=1 on every RLAT cycle; it drops on the same edge SEND begins.
- Not defined: the split port is tied to 0; RLAT timing is identical.

Test Plan:
1. Write addr 0x005, LEN=0, data 0xA5; then read 0x005, LEN=0 -> rd_bus 1,0,1,0,0,1,0,1; slave_valid rises 5 cycles after the last header bit; 8 consecutive valid cycles with master_ready=1.
2. Burst write 0x0FE, LEN=3, data 0x11,0x22,0x33,0x44; burst read 0x0FE, LEN=3 -> same 32 bits back-to-back; mem[0x000]=0x33 and mem[0x001]=0x44.
3. Read 0x005 with master_ready=0 for 3 cycles after bit 2 -> rd_bus and slave_valid stable during the stall; all 8 bits delivered in order; no duplicates or drops.
4. master_valid=0 after 5 address bits, then read 0x005 -> returns 0xA5 (unchanged); FSM back in IDLE within 1 cycle of the drop.
5. Header addr 0x100 (>= MEM_DEPTH), mode=1 -> error=1 for exactly 1 cycle; slave_ready=0 after ERR; no write; slave_valid never asserted.
6. Read with SLAVE_SPLIT_EN defined -> split=1 for exactly 4 cycles, then slave_valid=1. Repeat with rst=1 asserted mid-SEND -> all outputs 0 the next cycle and IDLE; a following read of 0x005 returns 0xA5.
